// File: rtl/matrix_sel_responder.sv
// matrix_sel_responder: responder end of the 6-bit sel / DATA_W-bit element bus used by the
// matrix ALU host. Holds 3x3 operand matrices A and B, result matrix R and a determinant
// register DET (all row-major), and executes transpose, add, subtract, scale-by-2, multiply
// and determinant on command.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   sel     access/command select: 0..8 write A, 9..17 write B, 18..26 read R, 27 read DET,
//           28 transpose, 29 add, 30 subtract, 31 multiply, 32 scale, 33 determinant
//   eleIn   write data for sel 0..17
//   eleOut  registered read data (1-cycle latency, 0 for non-read codes)
//   busy    high while the multiply or determinant engine runs
//   done    one-cycle pulse when an operation's results are committed
module matrix_sel_responder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        sel,
    input  logic [DATA_W-1:0] eleIn,
    output logic [DATA_W-1:0] eleOut,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0] MulLast = 5'(MUL_CYCLES);
    localparam logic [4:0] DetLast = 5'd6;

    typedef enum logic [1:0] {StIdle, StMul, StDet, StCommit} state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] a_q [9];
    logic [DATA_W-1:0] b_q [9];
    logic [DATA_W-1:0] r_q [9];
    logic [DATA_W-1:0] det_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] eleout_q;
    logic              single_done_q;
    logic [5:0]        sel_q;
    logic [4:0]        cnt_q;
    logic [1:0]        i_q, j_q, k_q;

    function automatic logic [3:0] idx3(input logic [1:0] row, input logic [1:0] col);
        return 4'({2'b00, row} * 4'd3 + {2'b00, col});
    endfunction

    logic              is_cmd, start;
    logic [3:0]        rd_idx, wb_idx, wa_idx;
    logic [3:0]        mul_a_idx, mul_b_idx, mul_r_idx;
    logic [DATA_W-1:0] mac_sum;
    logic [DATA_W-1:0] dx, dy, dz, det_next;
    logic              dneg;

    assign is_cmd = (sel >= 6'd28) && (sel <= 6'd33);
    // Edge-triggered on sel: a held command runs once; commands while not idle are dropped.
    assign start  = is_cmd && (sel != sel_q) && (state_q == StIdle);
    assign busy   = (state_q == StMul) || (state_q == StDet);
    assign done   = (state_q == StCommit) || single_done_q;
    assign eleOut = eleout_q;

    assign wa_idx = sel[3:0];
    assign wb_idx = 4'(sel - 6'd9);
    assign rd_idx = 4'(sel - 6'd18);

    assign mul_a_idx = idx3(i_q, k_q);
    assign mul_b_idx = idx3(k_q, j_q);
    assign mul_r_idx = idx3(i_q, j_q);
    assign mac_sum   = acc_q + a_q[mul_a_idx] * b_q[mul_b_idx];

    // Cofactor expansion along row 0, one signed triple product per step.
    always_comb begin
        dx   = '0;
        dy   = '0;
        dz   = '0;
        dneg = 1'b0;
        case (cnt_q)
            5'd0: begin dx = a_q[0]; dy = a_q[4]; dz = a_q[8]; end
            5'd1: begin dx = a_q[0]; dy = a_q[5]; dz = a_q[7]; dneg = 1'b1; end
            5'd2: begin dx = a_q[1]; dy = a_q[3]; dz = a_q[8]; dneg = 1'b1; end
            5'd3: begin dx = a_q[1]; dy = a_q[5]; dz = a_q[6]; end
            5'd4: begin dx = a_q[2]; dy = a_q[3]; dz = a_q[7]; end
            5'd5: begin dx = a_q[2]; dy = a_q[4]; dz = a_q[6]; dneg = 1'b1; end
            default: ;
        endcase
    end

    assign det_next = dneg ? (acc_q - dx * dy * dz) : (acc_q + dx * dy * dz);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start && sel == 6'd31) state_d = StMul;
                else if (start && sel == 6'd33) state_d = StDet;
            end
            StMul:    if (cnt_q == MulLast) state_d = StCommit;
            StDet:    if (cnt_q == DetLast) state_d = StCommit;
            StCommit: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 9; n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                r_q[n] <= '0;
            end
            det_q         <= '0;
            acc_q         <= '0;
            eleout_q      <= '0;
            single_done_q <= 1'b0;
            sel_q         <= 6'h3F;
            cnt_q         <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
        end else begin
            sel_q         <= sel;
            single_done_q <= 1'b0;

            if (sel >= 6'd18 && sel <= 6'd26) eleout_q <= r_q[rd_idx];
            else if (sel == 6'd27)            eleout_q <= det_q;
            else                              eleout_q <= '0;

            // Operands are read live by the engines, so writes are locked out while busy.
            if (!busy) begin
                if (sel < 6'd9)       a_q[wa_idx] <= eleIn;
                else if (sel < 6'd18) b_q[wb_idx] <= eleIn;
            end

            if (start) begin
                case (sel)
                    6'd28: begin
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                r_q[r*3+c] <= a_q[c*3+r];
                        single_done_q <= 1'b1;
                    end
                    6'd29: begin
                        for (int n = 0; n < 9; n++) r_q[n] <= a_q[n] + b_q[n];
                        single_done_q <= 1'b1;
                    end
                    6'd30: begin
                        for (int n = 0; n < 9; n++) r_q[n] <= a_q[n] - b_q[n];
                        single_done_q <= 1'b1;
                    end
                    6'd32: begin
                        for (int n = 0; n < 9; n++) r_q[n] <= a_q[n] + a_q[n];
                        single_done_q <= 1'b1;
                    end
                    default: begin
                        // Multiply or determinant: clear the sequencer.
                        acc_q <= '0;
                        cnt_q <= '0;
                        i_q   <= '0;
                        j_q   <= '0;
                        k_q   <= '0;
                    end
                endcase
            end

            case (state_q)
                StMul: begin
                    if (cnt_q != MulLast) begin
                        cnt_q <= cnt_q + 5'd1;
                        if (k_q == 2'd2) begin
                            r_q[mul_r_idx] <= mac_sum;
                            acc_q          <= '0;
                            k_q            <= '0;
                            if (j_q == 2'd2) begin
                                j_q <= '0;
                                i_q <= i_q + 2'd1;
                            end else begin
                                j_q <= j_q + 2'd1;
                            end
                        end else begin
                            acc_q <= mac_sum;
                            k_q   <= k_q + 2'd1;
                        end
                    end
                end
                StDet: begin
                    if (cnt_q != DetLast) begin
                        acc_q <= det_next;
                        cnt_q <= cnt_q + 5'd1;
                    end else begin
                        // DET keeps its old value for readers until the engine finishes.
                        det_q <= acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_sel_responder.sv
module tb_matrix_sel_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  sel;
    logic [31:0] eleIn;
    logic [31:0] eleOut;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matrix_sel_responder #(
        .DATA_W     (32),
        .MUL_CYCLES (27)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .eleIn  (eleIn),
        .eleOut (eleOut),
        .busy   (busy),
        .done   (done)
    );

    logic [31:0] seq    [9];
    logic [31:0] a2     [9];
    logic [31:0] b2     [9];
    logic [31:0] zeros  [9];
    logic [31:0] e_tr   [9];
    logic [31:0] e_add  [9];
    logic [31:0] e_mul  [9];
    logic [31:0] e_sub2 [9];
    logic [31:0] e_mul2 [9];
    logic [31:0] wrap_a [9];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] av [9], input logic [31:0] bv [9]);
        for (int i = 0; i < 9; i++) begin
            sel = 6'(i); eleIn = av[i]; tick;
        end
        for (int i = 0; i < 9; i++) begin
            sel = 6'(9 + i); eleIn = bv[i]; tick;
        end
        sel = 6'd40; eleIn = '0; tick;
    endtask

    task automatic run_single(input logic [5:0] code, input string tag);
        sel = code; tick;
        check({tag, " done"}, {31'b0, done}, 32'd1);
        sel = 6'd40; tick;
        check({tag, " done low"}, {31'b0, done}, 32'd0);
    endtask

    task automatic check_r(input string tag, input logic [31:0] exp [9]);
        for (int i = 0; i < 9; i++) begin
            sel = 6'(18 + i); tick;
            check($sformatf("%s R%0d", tag, i), eleOut, exp[i]);
        end
        sel = 6'd40;
    endtask

    // Holds a command for `cycles` cycles, counting busy cycles and done pulses.
    task automatic run_long(input logic [5:0] code, input int cycles, input int exp_busy,
                            input int exp_done_at, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        sel = code;
        for (int t = 1; t <= cycles; t++) begin
            tick;
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = t;
            end
        end
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " done latency"}, 32'(done_at), 32'(exp_done_at));
        sel = 6'd40; tick;
    endtask

    initial begin
        int dcnt;
        seq    = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        a2     = '{0, 2, 2, 3, 4, 8, 6, 17, 18};
        b2     = '{10, 11, 12, 3, 4, 5, 6, 7, 0};
        zeros  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        e_tr   = '{0, 3, 6, 1, 4, 7, 2, 5, 8};
        e_add  = '{0, 2, 4, 6, 8, 10, 12, 14, 16};
        e_mul  = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
        e_sub2 = '{-10, -9, -10, 0, 0, 3, 0, 10, 18};
        e_mul2 = '{18, 22, 10, 90, 105, 56, 219, 260, 157};
        wrap_a = '{32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        reset = 1'b1; sel = 6'd40; eleIn = '0;
        tick; tick;
        check("reset eleOut", eleOut, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        reset = 1'b0;
        sel = 6'd27; tick;
        check("reset DET", eleOut, 32'd0);
        sel = 6'd40; tick;

        // Single-cycle ops on A=B=[0..8]
        load(seq, seq);
        run_single(6'd28, "transpose");
        check_r("transpose", e_tr);
        run_single(6'd29, "add");
        check_r("add", e_add);
        run_single(6'd30, "sub");
        check_r("sub", zeros);

        // Multiply held for 40 cycles runs exactly once
        run_long(6'd31, 40, 28, 29, "mul");
        check_r("mul", e_mul);
        run_single(6'd32, "scale");
        check_r("scale", e_add);
        run_long(6'd33, 20, 7, 8, "det");
        sel = 6'd27; tick;
        check("det seq", eleOut, 32'd0);
        sel = 6'd40; tick;

        // Second operand set
        load(a2, b2);
        run_single(6'd30, "sub2");
        check_r("sub2", e_sub2);
        run_long(6'd31, 40, 28, 29, "mul2");
        check_r("mul2", e_mul2);
        run_long(6'd33, 20, 7, 8, "det2");
        sel = 6'd27; tick;
        check("det2 value", eleOut, 32'd42);
        sel = 6'd40; tick;

        // Writes and commands during multiply are ignored
        run_single(6'd28, "pre-interfere");
        sel = 6'd31; tick;
        dcnt = 0;
        for (int t = 1; t < 40; t++) begin
            if (t == 5) begin sel = 6'd0; eleIn = 32'd99; end
            if (t == 6) begin sel = 6'd29; eleIn = '0; end
            if (t == 7) sel = 6'd40;
            tick;
            dcnt += int'(done);
        end
        check("interfere done pulses", 32'(dcnt), 32'd1);
        check_r("interfere mul", e_mul2);
        run_single(6'd28, "post-interfere");
        sel = 6'd18; tick;
        check("A0 unchanged", eleOut, 32'd0);
        sel = 6'd19; tick;
        check("A3 via transpose", eleOut, 32'd3);
        sel = 6'd40; tick;

        // Reset in the middle of a multiply
        run_single(6'd30, "pre-reset");
        sel = 6'd31; tick;
        for (int t = 0; t < 9; t++) begin
            sel = 6'd40; tick;
        end
        sel = 6'd18; tick;
        check("busy before reset", {31'b0, busy}, 32'd1);
        check("read during busy", eleOut, 32'd18);
        reset = 1'b1; tick;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort eleOut", eleOut, 32'd0);
        reset = 1'b0; sel = 6'd40; tick;
        check_r("abort R", zeros);
        load(a2, b2);
        run_long(6'd31, 40, 28, 29, "mul after reset");
        check_r("mul after reset", e_mul2);

        // Wraparound and held single-cycle command
        load(wrap_a, zeros);
        sel = 6'd32;
        dcnt = 0;
        for (int t = 0; t < 10; t++) begin
            tick;
            dcnt += int'(done);
        end
        check("scale hold done pulses", 32'(dcnt), 32'd1);
        sel = 6'd18; tick;
        check("scale wrap R0", eleOut, 32'hFFFFFFFE);
        sel = 6'd19; tick;
        check("scale wrap R1", eleOut, 32'd0);
        sel = 6'd40; tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
